// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl
//   Stopwatch control unit. Conditions three push-buttons into single-cycle
//   events, sequences IDLE/RUN/PAUSE, runs the centisecond prescaler and keeps
//   the MM:SS.cc time as six BCD digit registers, with a lap snapshot.
//
// Parameters
//   CLK_FREQ  clock frequency in Hz
//   TICK_HZ   count rate in Hz (DIV = CLK_FREQ/TICK_HZ, must be >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_start  start/pause request (async level)
//   btn_clear  clear request (async level)
//   btn_lap    lap freeze/unfreeze request (async level)
//   dig0..dig5 BCD digits: cs units, cs tens, s units, s tens, m units, m tens
//   running    high in RUN
//   frozen     high while the lap snapshot is displayed
//   overflow   sticky, set on wrap past 59:59.99
module cronometro_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic       running,
  output logic       frozen,
  output logic       overflow
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  // Per-digit wrap values, index 0 = centisecond units.
  localparam logic [5:0][3:0] TOP = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  // Button bit positions in the conditioning vectors.
  localparam int unsigned B_START = 0;
  localparam int unsigned B_CLEAR = 1;
  localparam int unsigned B_LAP   = 2;

  // ---------------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer plus edge register per button.
  // ---------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] prev_q;
  logic [2:0] ev;

  assign btn_raw = {btn_lap, btn_clear, btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign ev = sync2_q & ~prev_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   do_clear;
  logic   do_freeze;
  logic   do_unfreeze;
  logic   frozen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the highest-priority event that applies in the current state acts;
  // clear does not apply in RUN, so a simultaneous lap still gets through.
  always_comb begin
    state_d     = state_q;
    do_clear    = 1'b0;
    do_freeze   = 1'b0;
    do_unfreeze = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev[B_START]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ev[B_START]) begin
          state_d = PAUSE;
        end else if (ev[B_LAP]) begin
          if (frozen_q) begin
            do_unfreeze = 1'b1;
          end else begin
            do_freeze = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (ev[B_START]) begin
          state_d = RUN;
        end else if (ev[B_CLEAR]) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else if (ev[B_LAP]) begin
          do_unfreeze = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler: advances only in RUN, so PAUSE keeps the phase for resume.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (state_q == RUN) && (presc_q == PMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (do_clear) begin
      presc_q <= '0;
    end else if (state_q == RUN) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD time registers with a same-edge ripple carry.
  // cy[i] = digit i advances this edge; cy[6] = wrap past 59:59.99.
  // ---------------------------------------------------------------------------
  logic [5:0][3:0] live_q;
  logic [5:0][3:0] snap_q;
  logic [6:0]      cy;
  logic            overflow_q;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] top);
    return (d == top) ? 4'd0 : d + 4'd1;
  endfunction

  always_comb begin
    cy    = '0;
    cy[0] = tick;
    for (int unsigned i = 0; i < 6; i++) begin
      cy[i+1] = cy[i] && (live_q[i] == TOP[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= '0;
    end else if (do_clear) begin
      live_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        if (cy[i]) begin
          live_q[i] <= bcd_inc(live_q[i], TOP[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (do_clear) begin
      overflow_q <= 1'b0;
    end else if (cy[6]) begin
      overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lap snapshot: captures the pre-edge live value on freeze.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q   <= '0;
      frozen_q <= 1'b0;
    end else if (do_clear) begin
      snap_q   <= '0;
      frozen_q <= 1'b0;
    end else if (do_freeze) begin
      snap_q   <= live_q;
      frozen_q <= 1'b1;
    end else if (do_unfreeze) begin
      frozen_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered sources, combinational live/snapshot select.
  // ---------------------------------------------------------------------------
  logic [5:0][3:0] disp;

  assign disp     = frozen_q ? snap_q : live_q;
  assign dig0     = disp[0];
  assign dig1     = disp[1];
  assign dig2     = disp[2];
  assign dig3     = disp[3];
  assign dig4     = disp[4];
  assign dig5     = disp[5];
  assign running  = (state_q == RUN);
  assign frozen   = frozen_q;
  assign overflow = overflow_q;

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Control unit for the stopwatch: turns three push-button inputs into start/pause/clear/lap commands, runs the centisecond timebase, and maintains the BCD time registers (MM:SS.cc). It sits between the board buttons and the six per-digit 7-segment decoders. Each `digN` output drives one decoder's 4-bit digit input directly.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `TICK_HZ`, default 100: count rate in Hz.
- `DIV = CLK_FREQ/TICK_HZ` is a localparam and must be ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `btn_start`  in  1  start/pause request; asynchronous level, active-high.
- `btn_clear`  in  1  clear request; asynchronous level, active-high.
- `btn_lap`  in  1  lap request (freeze/unfreeze the display); asynchronous level, active-high.
- `dig0`..`dig5`  out  4 each  BCD digits, in order: centisecond units, centisecond tens, second units, second tens, minute units, minute tens.
- `running`  out  1  high in state RUN.
- `frozen`  out  1  high while the lap snapshot is displayed.
- `overflow`  out  1  sticky; set on wrap past 59:59.99.

## Operation
- Input conditioning, per button:
  - two-flop synchronizer, then an edge register;
  - `ev = sync2 & ~prev` is a 1-cycle event;
  - a held button produces exactly one event;
  - no debounce; that is the board wrapper's job.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start → RUN.
  - RUN + start → PAUSE.
  - PAUSE + start → RUN.
  - PAUSE + clear → IDLE.
  - Clear in RUN is ignored.
  - Clear in IDLE is a no-op.
- Same-cycle events, priority start > clear > lap:
  - only the highest-priority event applicable in the current state acts;
  - the others are dropped.
- Prescaler:
  - counts 0..DIV-1 only in RUN and holds in PAUSE;
  - `tick` = RUN && prescaler == DIV-1; the prescaler wraps to 0 on that edge.
- Time registers:
  - cs counts 0..99 on tick;
  - ss increments when cs wraps 99→0 and counts 0..59;
  - mm increments when ss wraps 59→0 and counts 0..59;
  - the carry chain resolves within the same edge.
- Wrap at 59:59.99 + tick:
  - all fields go to 00:00.00;
  - `overflow` is set;
  - counting continues.
- Lap:
  - in RUN, a lap event toggles `frozen`;
  - on freeze, the current cs/ss/mm are copied into snapshot registers;
  - while frozen, `digN` show the snapshot and the counters keep running;
  - in PAUSE, lap clears `frozen` if set and is otherwise ignored;
  - in IDLE, lap is ignored.
- Entering IDLE via clear zeroes:
  - cs/ss/mm, the snapshot and the prescaler;
  - `frozen` and `overflow`.
- `digN` are registered-source combinational selects (live or snapshot). They are always valid BCD, 0–9.

## Timing
- Reset values, asserted asynchronously:
  - state IDLE;
  - all `digN` = 0, `running` = 0, `frozen` = 0, `overflow` = 0;
  - synchronizers, prescaler and snapshot = 0.
- Reset mid-count aborts immediately; there is no partial state.
- Button latency: a button rising before edge k gives its event during cycle k+1→k+2, and the state/flag updates on edge k+2.
  - Example: `running` rises 3 edges after `btn_start` rises.
- First tick: the first cs increment occurs DIV edges after the edge that entered RUN.
- Resume from PAUSE continues from the held prescaler value; there is no phase loss.
- Pause takes effect on the same edge as the state change. If that edge coincides with a tick, the tick still counts.
- Display update: `digN` change on the same edge as the register update, with zero added latency.

## Test plan
Bench parameters: CLK_FREQ=1000, TICK_HZ=100, so DIV=10.

- **Reset:** assert `rst_n`=0 mid-count at 00:03.47 → all outputs 0 asynchronously, before the next clock edge.
- **Start:** pulse `btn_start` high for 5 cycles → `running`=1 on edge 3; `dig0`=1 exactly 10 edges later; after 1000 clocks the display reads 00:01.00.
- **Pause/resume:**
  - pause at prescaler=4 and hold 50 cycles → digits frozen;
  - resume → next cs increment occurs 6 edges after RUN re-entry.
- **Carry and overflow:** run 360000 ticks → wrap to 00:00.00 with `overflow`=1; `dig3` never exceeds 5 and `dig5` never exceeds 5.
- **Lap:**
  - lap at 00:00.25 → `frozen`=1 and digits hold 00:00.25 while counting continues;
  - second lap → live value shown (e.g. 00:00.40).
- **Clear:**
  - clear in RUN → ignored;
  - `btn_start` and `btn_clear` in the same cycle while RUN → PAUSE only;
  - clear in PAUSE → IDLE with all zeros and `overflow`=0.
